// File: rtl/clarke_vect_feeder.sv
// rtl/clarke_vect_feeder.sv - Clarke transform front end that prepares operands for a vectoring CORDIC
// beta = (ia + 2*ib)/sqrt(3) via a 17-cycle shift-add multiply; operands are folded into x >= 0.
module clarke_vect_feeder #(
  parameter logic [16:0] K_INV_SQRT3 = 17'd75674
) (
  input  logic        sys_clk_i,
  input  logic        reset_n_i,
  input  logic        valid_i,
  input  logic [17:0] ia_i,
  input  logic [17:0] ib_i,
  output logic        ready_o,
  output logic        drop_o,
  output logic        start_o,
  output logic [17:0] x_o,
  output logic [17:0] y_o,
  output logic [17:0] theta_o,
  output logic        quad_o,
  input  logic        done_i
);

  typedef enum logic [2:0] {IDLE, MUL, PREP, START, WAIT} state_t;

  localparam logic signed [17:0] MAX18 = 18'sd131071;
  localparam logic signed [17:0] MIN18 = -18'sd131072;

  state_t             state;
  logic signed [17:0] alpha;
  logic signed [36:0] acc;
  logic signed [36:0] mcand;
  logic        [16:0] coef;
  logic        [4:0]  cnt;

  logic signed [36:0] p_sh;
  logic signed [17:0] beta;
  logic signed [17:0] neg_alpha;
  logic signed [17:0] neg_beta;

  assign theta_o = '0;

  // Floor shift of the product, clamped to the 18-bit operand range.
  always_comb begin
    p_sh = acc >>> 17;
    if (p_sh > 37'(MAX18))
      beta = MAX18;
    else if (p_sh < 37'(MIN18))
      beta = MIN18;
    else
      beta = p_sh[17:0];
    neg_alpha = (alpha == MIN18) ? MAX18 : -alpha;
    neg_beta  = (beta  == MIN18) ? MAX18 : -beta;
  end

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      ready_o <= 1'b1;
      drop_o  <= 1'b0;
      start_o <= 1'b0;
      x_o     <= '0;
      y_o     <= '0;
      quad_o  <= 1'b0;
      alpha   <= '0;
      acc     <= '0;
      mcand   <= '0;
      coef    <= '0;
      cnt     <= '0;
    end else begin
      drop_o  <= valid_i && (state != IDLE);
      start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            alpha   <= ia_i;
            mcand   <= {{19{ia_i[17]}}, ia_i} + {{18{ib_i[17]}}, ib_i, 1'b0};
            acc     <= '0;
            coef    <= K_INV_SQRT3;
            cnt     <= '0;
            ready_o <= 1'b0;
            state   <= MUL;
          end
        end
        MUL: begin
          if (coef[0])
            acc <= acc + mcand;
          mcand <= mcand <<< 1;
          coef  <= coef >> 1;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd16)
            state <= PREP;
        end
        PREP: begin
          if (!alpha[17]) begin
            x_o    <= alpha;
            y_o    <= beta;
            quad_o <= 1'b0;
          end else begin
            x_o    <= neg_alpha;
            y_o    <= neg_beta;
            quad_o <= 1'b1;
          end
          state <= START;
        end
        START: begin
          start_o <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          if (done_i) begin
            ready_o <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          ready_o <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
